// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction/flag inputs and control outputs between datapath and controller
interface multicycle_controller_if;
  logic [31:12] Instr;
  logic [3:0] ALUFlags;
  logic PCWrite, IRWrite, RegWrite, MemWrite, MemByte, AdrSrc;
  logic [1:0] RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl;
  modport master (
    output Instr, ALUFlags,
    input PCWrite, IRWrite, RegWrite, MemWrite, MemByte, AdrSrc,
    input RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl
  );
  modport slave (
    input Instr, ALUFlags,
    output PCWrite, IRWrite, RegWrite, MemWrite, MemByte, AdrSrc,
    output RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM control unit for a multicycle ARM-subset processor
module multicycle_controller (
  input logic clk,
  input logic reset,
  multicycle_controller_if.slave bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH
  } state_t;
  state_t state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic [3:0] cond, cmd, rd;
  logic [1:0] op, alu_dec;
  logic [5:0] funct;
  logic n, z, c, v, cond_ex, no_write, arith, exec;
  logic pc_w, ir_w, reg_w, mem_w;
  assign cond = bus.Instr[31:28];
  assign op = bus.Instr[27:26];
  assign funct = bus.Instr[25:20];
  assign rd = bus.Instr[15:12];
  assign cmd = funct[4:1];
  assign {n, z, c, v} = flags_q;
  always_comb begin
    case (cond)
      4'h0: cond_ex = z;
      4'h1: cond_ex = !z;
      4'h2: cond_ex = c;
      4'h3: cond_ex = !c;
      4'h4: cond_ex = n;
      4'h5: cond_ex = !n;
      4'h6: cond_ex = v;
      4'h7: cond_ex = !v;
      4'h8: cond_ex = c && !z;
      4'h9: cond_ex = !c || z;
      4'ha: cond_ex = n == v;
      4'hb: cond_ex = n != v;
      4'hc: cond_ex = !z && (n == v);
      4'hd: cond_ex = z || (n != v);
      4'he: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
  assign alu_dec = cmd == 4'b0100 ? 2'b00 :
                   cmd == 4'b0010 ? 2'b01 :
                   cmd == 4'b0000 ? 2'b10 :
                   cmd == 4'b1100 ? 2'b11 :
                   cmd == 4'b1010 ? 2'b01 : 2'b00;
  assign no_write = cmd == 4'b1010;
  assign arith = cmd inside {4'b0100, 4'b0010, 4'b1010};
  assign exec = state_q inside {EXECUTER, EXECUTEI};
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: state_d = op == 2'b01 ? MEMADR :
                        op == 2'b10 ? BRANCH :
                        op == 2'b11 ? FETCH :
                        funct[5] ? EXECUTEI : EXECUTER;
      MEMADR: state_d = funct[0] ? MEMRD : MEMWR;
      MEMRD: state_d = MEMWB;
      EXECUTER, EXECUTEI: state_d = ALUWB;
      default: state_d = FETCH;
    endcase
    flags_d = (exec && funct[0] && cond_ex) ?
              {bus.ALUFlags[3:2], arith ? bus.ALUFlags[1:0] : flags_q[1:0]} : flags_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end
  always_comb begin
    pc_w = 1'b0;
    ir_w = 1'b0;
    reg_w = 1'b0;
    mem_w = 1'b0;
    bus.MemByte = 1'b0;
    bus.AdrSrc = 1'b0;
    bus.RegSrc = {op == 2'b10, op == 2'b01};
    bus.ImmSrc = op;
    bus.ALUSrcA = 2'b00;
    bus.ALUSrcB = 2'b00;
    bus.ResultSrc = 2'b00;
    bus.ALUControl = 2'b00;
    case (state_q)
      FETCH: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        bus.ResultSrc = 2'b10;
        ir_w = 1'b1;
        pc_w = 1'b1;
      end
      DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      MEMADR: bus.ALUSrcB = 2'b01;
      MEMRD: begin
        bus.AdrSrc = 1'b1;
        bus.MemByte = funct[2];
      end
      MEMWB: begin
        bus.AdrSrc = 1'b1;
        bus.MemByte = funct[2];
        bus.ResultSrc = 2'b01;
        reg_w = cond_ex;
      end
      MEMWR: begin
        bus.AdrSrc = 1'b1;
        bus.MemByte = funct[2];
        mem_w = cond_ex;
      end
      EXECUTER: bus.ALUControl = alu_dec;
      EXECUTEI: begin
        bus.ALUSrcB = 2'b01;
        bus.ALUControl = alu_dec;
      end
      ALUWB: reg_w = cond_ex && !no_write;
      BRANCH: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        pc_w = cond_ex;
      end
      default: ;
    endcase
    if (state_q inside {MEMWB, ALUWB} && rd == 4'hf) pc_w = reg_w;
  end
  assign bus.PCWrite = pc_w && !reset;
  assign bus.IRWrite = ir_w && !reset;
  assign bus.RegWrite = reg_w && !reset;
  assign bus.MemWrite = mem_w && !reset;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed-vector check of the multicycle controller outputs and flags
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [17:0] ctl;
  multicycle_controller_if bus ();
  multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign ctl = {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.MemByte, bus.AdrSrc,
                bus.RegSrc, bus.ImmSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUControl};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask
  task automatic run(input string tag, input logic [19:0] ins, input logic [3:0] af, input int cyc,
                     input logic [17:0] e0, input logic [17:0] e1, input logic [17:0] e2,
                     input logic [17:0] e3, input logic [17:0] e4);
    logic [17:0] e;
    bus.Instr = ins;
    bus.ALUFlags = af;
    for (int i = 0; i < cyc; i++) begin
      e = i == 0 ? e0 : i == 1 ? e1 : i == 2 ? e2 : i == 3 ? e3 : e4;
      @(negedge clk);
      chk($sformatf("%s c%0d", tag, i), 32'(ctl), 32'(e));
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    bus.Instr = 20'he0821;
    bus.ALUFlags = 4'b0000;
    @(negedge clk);
    chk("rst_ctl", 32'(ctl), 32'(18'b0_0_0_0_0_0_00_00_01_10_10_00));
    chk("rst_flags", 32'(dut.flags_q), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    run("add", 20'he0821, 4'b1111, 4,
        18'b1_1_0_0_0_0_00_00_01_10_10_00, 18'b0_0_0_0_0_0_00_00_01_10_10_00,
        18'b0_0_0_0_0_0_00_00_00_00_00_00, 18'b0_0_1_0_0_0_00_00_00_00_00_00, 18'b0);
    chk("add_flags", 32'(dut.flags_q), 32'h0);
    run("ldr", 20'he5912, 4'b0000, 5,
        18'b1_1_0_0_0_0_01_01_01_10_10_00, 18'b0_0_0_0_0_0_01_01_01_10_10_00,
        18'b0_0_0_0_0_0_01_01_00_01_00_00, 18'b0_0_0_0_0_1_01_01_00_00_00_00,
        18'b0_0_1_0_0_1_01_01_00_00_01_00);
    run("strb", 20'he5c12, 4'b0000, 4,
        18'b1_1_0_0_0_0_01_01_01_10_10_00, 18'b0_0_0_0_0_0_01_01_01_10_10_00,
        18'b0_0_0_0_0_0_01_01_00_01_00_00, 18'b0_0_0_1_1_1_01_01_00_00_00_00, 18'b0);
    run("subs", 20'he0511, 4'b0100, 4,
        18'b1_1_0_0_0_0_00_00_01_10_10_00, 18'b0_0_0_0_0_0_00_00_01_10_10_00,
        18'b0_0_0_0_0_0_00_00_00_00_00_01, 18'b0_0_1_0_0_0_00_00_00_00_00_00, 18'b0);
    chk("subs_flags", 32'(dut.flags_q), 32'b0100);
    run("beq", 20'h0a000, 4'b0000, 3,
        18'b1_1_0_0_0_0_10_10_01_10_10_00, 18'b0_0_0_0_0_0_10_10_01_10_10_00,
        18'b1_0_0_0_0_0_10_10_10_01_00_00, 18'b0, 18'b0);
    run("bne", 20'h1a000, 4'b0000, 3,
        18'b1_1_0_0_0_0_10_10_01_10_10_00, 18'b0_0_0_0_0_0_10_10_01_10_10_00,
        18'b0_0_0_0_0_0_10_10_10_01_00_00, 18'b0, 18'b0);
    run("addne", 20'h10821, 4'b1111, 4,
        18'b1_1_0_0_0_0_00_00_01_10_10_00, 18'b0_0_0_0_0_0_00_00_01_10_10_00,
        18'b0_0_0_0_0_0_00_00_00_00_00_00, 18'b0, 18'b0);
    chk("addne_flags", 32'(dut.flags_q), 32'b0100);
    run("cmp", 20'he1500, 4'b1011, 4,
        18'b1_1_0_0_0_0_00_00_01_10_10_00, 18'b0_0_0_0_0_0_00_00_01_10_10_00,
        18'b0_0_0_0_0_0_00_00_00_00_00_01, 18'b0, 18'b0);
    chk("cmp_flags", 32'(dut.flags_q), 32'b1011);
    run("orrs", 20'he1911, 4'b0100, 4,
        18'b1_1_0_0_0_0_00_00_01_10_10_00, 18'b0_0_0_0_0_0_00_00_01_10_10_00,
        18'b0_0_0_0_0_0_00_00_00_00_00_11, 18'b0_0_1_0_0_0_00_00_00_00_00_00, 18'b0);
    chk("orrs_flags", 32'(dut.flags_q), 32'b0111);
    run("orri", 20'he3911, 4'b1000, 4,
        18'b1_1_0_0_0_0_00_00_01_10_10_00, 18'b0_0_0_0_0_0_00_00_01_10_10_00,
        18'b0_0_0_0_0_0_00_00_00_01_00_11, 18'b0_0_1_0_0_0_00_00_00_00_00_00, 18'b0);
    chk("orri_flags", 32'(dut.flags_q), 32'b1011);
    run("add_pc", 20'he082f, 4'b0000, 4,
        18'b1_1_0_0_0_0_00_00_01_10_10_00, 18'b0_0_0_0_0_0_00_00_01_10_10_00,
        18'b0_0_0_0_0_0_00_00_00_00_00_00, 18'b1_0_1_0_0_0_00_00_00_00_00_00, 18'b0);
    run("nop", 20'hec000, 4'b0000, 2,
        18'b1_1_0_0_0_0_00_11_01_10_10_00, 18'b0_0_0_0_0_0_00_11_01_10_10_00,
        18'b0, 18'b0, 18'b0);
    run("strb2", 20'he5c12, 4'b0000, 3,
        18'b1_1_0_0_0_0_01_01_01_10_10_00, 18'b0_0_0_0_0_0_01_01_01_10_10_00,
        18'b0_0_0_0_0_0_01_01_00_01_00_00, 18'b0, 18'b0);
    reset = 1'b1;
    #1;
    chk("rst_mw", 32'(bus.MemWrite), 32'h0);
    chk("rst_adr", 32'(bus.AdrSrc), 32'h1);
    @(posedge clk);
    #1;
    chk("rst_flags2", 32'(dut.flags_q), 32'h0);
    @(negedge clk);
    chk("rst_ctl2", 32'(ctl), 32'(18'b0_0_0_0_0_0_01_01_01_10_10_00));
    @(posedge clk);
    #1 reset = 1'b0;
    run("add2", 20'he0821, 4'b0000, 4,
        18'b1_1_0_0_0_0_00_00_01_10_10_00, 18'b0_0_0_0_0_0_00_00_01_10_10_00,
        18'b0_0_0_0_0_0_00_00_00_00_00_00, 18'b0_0_1_0_0_0_00_00_00_00_00_00, 18'b0);
    run("end", 20'hec000, 4'b0000, 1,
        18'b1_1_0_0_0_0_00_11_01_10_10_00, 18'b0, 18'b0, 18'b0, 18'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
